// File: rtl/ndp_credit_reg_responder.sv
// Credit register file responder: predicated read-modify-write with 2-cycle response and init port.
// Optional CREDIT_SUB_SAT_EN makes ADD/SUB saturate instead of wrapping.
module ndp_credit_reg_responder #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              net_creditReg_req_valid,
  input  logic [IDX_W-1:0]  net_creditReg_req_bits_index,
  input  logic [DATA_W-1:0] net_creditReg_req_bits_data_1,
  input  logic [7:0]        net_creditReg_req_bits_opCode_1,
  input  logic [DATA_W-1:0] net_creditReg_req_bits_data_0,
  input  logic [7:0]        net_creditReg_req_bits_opCode_0,
  input  logic              net_creditReg_req_bits_predicate,
  output logic              net_creditReg_resp_valid,
  output logic [DATA_W-1:0] net_creditReg_resp_bits_new_val,
  input  logic              init_valid,
  output logic              init_ready,
  input  logic [IDX_W-1:0]  init_index,
  input  logic [DATA_W-1:0] init_data,
  output logic              clear_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DepthIdx = IDX_W'(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  localparam logic [7:0] OpRead  = 8'd0;
  localparam logic [7:0] OpWrite = 8'd1;
  localparam logic [7:0] OpAdd   = 8'd2;
  localparam logic [7:0] OpSub   = 8'd3;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q;
  logic              clear_busy_q;
  logic [AW-1:0]     sweep_q;

  logic              s1_valid_q;
  logic              s1_live_q;
  logic [AW-1:0]     s1_addr_q;
  logic [7:0]        s1_op_q;
  logic [DATA_W-1:0] s1_data_q;

  logic              byp_valid_q;
  logic [AW-1:0]     byp_addr_q;
  logic [DATA_W-1:0] byp_data_q;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_val_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_dout_q;

  logic              req_in_range;
  logic              init_in_range;
  logic              init_fire;
  logic [7:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] add_res;
  logic [DATA_W-1:0] sub_res;
  logic [DATA_W-1:0] new_val;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign req_in_range  = net_creditReg_req_bits_index < DepthIdx;
  assign init_in_range = init_index < DepthIdx;
  assign init_ready    = !s1_valid_q && !clear_busy_q;
  assign init_fire     = init_valid && init_ready;

  assign sel_op   = net_creditReg_req_bits_predicate ? net_creditReg_req_bits_opCode_1
                                                     : net_creditReg_req_bits_opCode_0;
  assign sel_data = net_creditReg_req_bits_predicate ? net_creditReg_req_bits_data_1
                                                     : net_creditReg_req_bits_data_0;

  // RAM returns old data on collision, so the write made at the read edge comes from here.
  assign operand = (byp_valid_q && (byp_addr_q == s1_addr_q)) ? byp_data_q : ram_dout_q;

`ifdef CREDIT_SUB_SAT_EN
  logic [DATA_W:0] add_wide;
  assign add_wide = {1'b0, operand} + {1'b0, s1_data_q};
  assign add_res  = add_wide[DATA_W] ? '1 : add_wide[DATA_W-1:0];
  assign sub_res  = (s1_data_q > operand) ? '0 : operand - s1_data_q;
`else
  assign add_res = operand + s1_data_q;
  assign sub_res = operand - s1_data_q;
`endif

  always_comb begin
    new_val = operand;
    case (s1_op_q)
      OpRead:  new_val = operand;
      OpWrite: new_val = s1_data_q;
      OpAdd:   new_val = add_res;
      OpSub:   new_val = sub_res;
      default: new_val = operand;
    endcase
  end

  // Single write port: sweep, then pipeline result, then init.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (reset) begin
      wr_en = 1'b0;
    end else if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
    end else if (s1_valid_q && s1_live_q) begin
      wr_en   = 1'b1;
      wr_addr = s1_addr_q;
      wr_data = new_val;
    end else if (init_fire && init_in_range) begin
      wr_en   = 1'b1;
      wr_addr = init_index[AW-1:0];
      wr_data = init_data;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    ram_dout_q <= mem[net_creditReg_req_bits_index[AW-1:0]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StClear;
      clear_busy_q <= 1'b1;
      sweep_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_live_q    <= 1'b0;
      s1_addr_q    <= '0;
      s1_op_q      <= '0;
      s1_data_q    <= '0;
      byp_valid_q  <= 1'b0;
      byp_addr_q   <= '0;
      byp_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_val_q   <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == LastIdx) begin
            state_q      <= StRun;
            clear_busy_q <= 1'b0;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
      endcase

      s1_valid_q <= net_creditReg_req_valid;
      s1_live_q  <= req_in_range && (state_q == StRun);
      s1_addr_q  <= net_creditReg_req_bits_index[AW-1:0];
      s1_op_q    <= sel_op;
      s1_data_q  <= sel_data;

      byp_valid_q <= wr_en;
      byp_addr_q  <= wr_addr;
      byp_data_q  <= wr_data;

      resp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        resp_val_q <= s1_live_q ? new_val : '0;
      end
    end
  end

  assign net_creditReg_resp_valid        = resp_valid_q;
  assign net_creditReg_resp_bits_new_val = resp_val_q;
  assign clear_busy                      = clear_busy_q;

endmodule

// File: tb/tb_ndp_credit_reg_responder.sv
// Directed bench for ndp_credit_reg_responder with hand-computed expectations.
module tb_ndp_credit_reg_responder;

  localparam logic [7:0] OP_READ  = 8'd0;
  localparam logic [7:0] OP_WRITE = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;

`ifdef CREDIT_SUB_SAT_EN
  localparam logic [15:0] SUB_EXP = 16'h0000;
  localparam logic [15:0] ADD_EXP = 16'hFFFF;
`else
  localparam logic [15:0] SUB_EXP = 16'hFFFD;
  localparam logic [15:0] ADD_EXP = 16'h0002;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        net_creditReg_req_valid = 1'b0;
  logic [15:0] net_creditReg_req_bits_index = '0;
  logic [15:0] net_creditReg_req_bits_data_1 = '0;
  logic [7:0]  net_creditReg_req_bits_opCode_1 = '0;
  logic [15:0] net_creditReg_req_bits_data_0 = '0;
  logic [7:0]  net_creditReg_req_bits_opCode_0 = '0;
  logic        net_creditReg_req_bits_predicate = 1'b0;
  logic        net_creditReg_resp_valid;
  logic [15:0] net_creditReg_resp_bits_new_val;
  logic        init_valid = 1'b0;
  logic        init_ready;
  logic [15:0] init_index = '0;
  logic [15:0] init_data = '0;
  logic        clear_busy;

  int n_checks = 0;
  int n_pass   = 0;

  ndp_credit_reg_responder dut (
    .clock                            (clock),
    .reset                            (reset),
    .net_creditReg_req_valid          (net_creditReg_req_valid),
    .net_creditReg_req_bits_index     (net_creditReg_req_bits_index),
    .net_creditReg_req_bits_data_1    (net_creditReg_req_bits_data_1),
    .net_creditReg_req_bits_opCode_1  (net_creditReg_req_bits_opCode_1),
    .net_creditReg_req_bits_data_0    (net_creditReg_req_bits_data_0),
    .net_creditReg_req_bits_opCode_0  (net_creditReg_req_bits_opCode_0),
    .net_creditReg_req_bits_predicate (net_creditReg_req_bits_predicate),
    .net_creditReg_resp_valid         (net_creditReg_resp_valid),
    .net_creditReg_resp_bits_new_val  (net_creditReg_resp_bits_new_val),
    .init_valid                       (init_valid),
    .init_ready                       (init_ready),
    .init_index                       (init_index),
    .init_data                        (init_data),
    .clear_busy                       (clear_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [15:0] idx, input logic pred,
                           input logic [7:0] op1, input logic [15:0] d1,
                           input logic [7:0] op0, input logic [15:0] d0);
    net_creditReg_req_valid          = 1'b1;
    net_creditReg_req_bits_index     = idx;
    net_creditReg_req_bits_predicate = pred;
    net_creditReg_req_bits_opCode_1  = op1;
    net_creditReg_req_bits_data_1    = d1;
    net_creditReg_req_bits_opCode_0  = op0;
    net_creditReg_req_bits_data_0    = d0;
  endtask

  // Response appears two cycles after the request cycle; valid and value checked together.
  task automatic req_check(input string tag, input logic [15:0] idx, input logic pred,
                           input logic [7:0] op1, input logic [15:0] d1,
                           input logic [7:0] op0, input logic [15:0] d0,
                           input logic [15:0] exp);
    drive_req(idx, pred, op1, d1, op0, d0);
    cyc();
    net_creditReg_req_valid = 1'b0;
    cyc();
    check(tag, {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val}, {1'b1, exp});
  endtask

  task automatic rd(input string tag, input logic [15:0] idx, input logic [15:0] exp);
    req_check(tag, idx, 1'b1, OP_READ, 16'h0, OP_WRITE, 16'hDEAD, exp);
  endtask

  task automatic init_write(input string tag, input logic [15:0] idx, input logic [15:0] data);
    int n = 0;
    init_valid = 1'b1;
    init_index = idx;
    init_data  = data;
    while (init_ready !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check(tag, {31'b0, init_ready}, 32'd1);
    cyc();
    init_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int bad;
    int bad2;

    // Reset for one edge, then watch the sweep
    cyc();
    reset = 1'b0;
    check("rst_clear_busy", {31'b0, clear_busy}, 32'd1);
    check("rst_resp_valid", {31'b0, net_creditReg_resp_valid}, 32'd0);
    check("rst_new_val", {16'b0, net_creditReg_resp_bits_new_val}, 32'd0);
    check("rst_init_ready", {31'b0, init_ready}, 32'd0);

    cnt = 0;
    bad = 0;
    while (clear_busy === 1'b1 && cnt < 1000) begin
      if (init_ready !== 1'b0) bad++;
      if (cnt == 120) drive_req(16'd3, 1'b1, OP_WRITE, 16'h0055, OP_WRITE, 16'h0055);
      if (cnt == 121) net_creditReg_req_valid = 1'b0;
      if (cnt == 122)
        check("clear_req_resp", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val},
              {1'b1, 16'h0});
      if (cnt == 123) check("clear_req_pulse", {31'b0, net_creditReg_resp_valid}, 32'd0);
      cnt++;
      cyc();
    end
    check("clear_len", cnt, 32'd128);
    check("clear_init_ready_low", bad, 32'd0);

    // Back-to-back reads of every entry
    bad = 0;
    for (int i = 0; i < 130; i++) begin
      if (i < 128) drive_req(i[15:0], 1'b0, OP_ADD, 16'h1, OP_READ, 16'h0);
      else net_creditReg_req_valid = 1'b0;
      if (i >= 2 && {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val} !== 17'h10000)
        bad++;
      cyc();
    end
    check("read_all_zero", bad, 32'd0);
    check("stream_end", {31'b0, net_creditReg_resp_valid}, 32'd0);

    // Init then add in the next cycle
    init_write("init5_ready", 16'd5, 16'h0010);
    req_check("init5_add3", 16'd5, 1'b1, OP_ADD, 16'd3, OP_WRITE, 16'hBEEF, 16'h0013);
    cyc();
    check("resp_pulse", {31'b0, net_creditReg_resp_valid}, 32'd0);
    rd("init5_read", 16'd5, 16'h0013);

    // Init and request in the same cycle: request must see init data via bypass
    init_valid = 1'b1;
    init_index = 16'd11;
    init_data  = 16'h0020;
    drive_req(16'd11, 1'b1, OP_READ, 16'h0, OP_WRITE, 16'h0);
    check("init11_ready", {31'b0, init_ready}, 32'd1);
    cyc();
    init_valid = 1'b0;
    net_creditReg_req_valid = 1'b0;
    check("init_ready_s1_busy", {31'b0, init_ready}, 32'd0);
    cyc();
    check("init_bypass", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val},
          {1'b1, 16'h0020});

    // Back-to-back same index with branch selection
    init_write("init7_ready", 16'd7, 16'd10);
    drive_req(16'd7, 1'b0, OP_WRITE, 16'h0099, OP_SUB, 16'd4);
    cyc();
    drive_req(16'd7, 1'b1, OP_ADD, 16'd1, OP_WRITE, 16'h0077);
    cyc();
    drive_req(16'd7, 1'b0, OP_ADD, 16'd5, OP_READ, 16'h0);
    check("b2b_sub", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val}, {1'b1, 16'd6});
    cyc();
    net_creditReg_req_valid = 1'b0;
    check("b2b_add", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val}, {1'b1, 16'd7});
    cyc();
    check("b2b_read", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val}, {1'b1, 16'd7});
    cyc();
    check("b2b_done", {31'b0, net_creditReg_resp_valid}, 32'd0);

    // ADD 1 three times on an entry holding 5
    init_write("init8_ready", 16'd8, 16'd5);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_req(16'd8, 1'b1, OP_ADD, 16'd1, OP_READ, 16'h0);
      else net_creditReg_req_valid = 1'b0;
      if (i >= 2 && {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val} !==
          {1'b1, 16'(i + 4)}) bad++;
      cyc();
    end
    check("add_chain_678", bad, 32'd0);

    // Overflow / underflow, opcode decode
    init_write("init9a_ready", 16'd9, 16'd2);
    req_check("sub_under", 16'd9, 1'b1, OP_SUB, 16'd5, OP_READ, 16'h0, SUB_EXP);
    init_write("init9b_ready", 16'd9, 16'hFFFE);
    req_check("add_over", 16'd9, 1'b0, OP_READ, 16'h0, OP_ADD, 16'd4, ADD_EXP);
    req_check("op_other_reads", 16'd9, 1'b1, 8'hAB, 16'h1234, OP_WRITE, 16'h0, ADD_EXP);
    req_check("write_op", 16'd9, 1'b0, OP_ADD, 16'd1, OP_WRITE, 16'hCAFE, 16'hCAFE);
    rd("write_persist", 16'd9, 16'hCAFE);

    // Init held during a request stream waits for the first idle cycle
    bad = 0;
    bad2 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4 || c == 6) drive_req(16'd12, 1'b1, OP_READ, 16'h0, OP_ADD, 16'h9);
      else net_creditReg_req_valid = 1'b0;
      if (c == 1) begin
        init_valid = 1'b1;
        init_index = 16'd12;
        init_data  = 16'h0042;
      end
      if (c >= 1 && c <= 4 && init_ready !== 1'b0) bad++;
      if (c == 5) check("init_wait_ready", {31'b0, init_ready}, 32'd1);
      if (c >= 2 && c <= 5 &&
          {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val} !== 17'h10000) bad2++;
      cyc();
      if (c == 5) init_valid = 1'b0;
    end
    check("stream_init_blocked", bad, 32'd0);
    check("stream_pre_init_vals", bad2, 32'd0);
    check("init_after_stream", {net_creditReg_resp_valid, net_creditReg_resp_bits_new_val},
          {1'b1, 16'h0042});

    // Out of range request and init
    req_check("oor_req", 16'd200, 1'b1, OP_WRITE, 16'h0055, OP_WRITE, 16'h0055, 16'h0);
    rd("oor_alias72", 16'd72, 16'h0);
    init_write("oor_init_ready", 16'd300, 16'h0077);
    rd("oor_alias44", 16'd44, 16'h0);

    // Reset with two requests in flight
    drive_req(16'd20, 1'b1, OP_WRITE, 16'h0011, OP_WRITE, 16'h0011);
    cyc();
    drive_req(16'd21, 1'b1, OP_WRITE, 16'h0022, OP_WRITE, 16'h0022);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    net_creditReg_req_valid = 1'b0;
    check("rst2_busy", {31'b0, clear_busy}, 32'd1);
    cnt = 0;
    bad = 0;
    while (clear_busy === 1'b1 && cnt < 1000) begin
      if (net_creditReg_resp_valid !== 1'b0) bad++;
      cnt++;
      cyc();
    end
    check("rst2_no_resp", bad, 32'd0);
    check("rst2_clear_len", cnt, 32'd128);
    rd("rst2_idx5_cleared", 16'd5, 16'h0);
    rd("rst2_idx21", 16'd21, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
